// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter that multiplexes N_CORES requesters onto a
// single-port RAM with a registered address (read data one cycle after the
// address is presented).
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   req           : per-core request
//   wrEn          : per-core write qualifier (1 = write, 0 = read)
//   address       : per-core address, core k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   dataIn        : per-core write data, core k at [k*DATA_WIDTH +: DATA_WIDTH]
//   gnt           : one-hot acceptance pulse, cycle after capture
//   rdValid       : one-hot read-data-valid pulse, two cycles after capture
//   dataOut       : read data broadcast (pass-through of ram_dataOut)
//   ram_wrEn      : RAM write enable
//   ram_address   : RAM address
//   ram_dataIn    : RAM write data
//   ram_dataOut   : RAM read data
module ram_arbiter #(
   parameter int DATA_WIDTH = 12,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int N_CORES    = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_CORES-1:0]              req,
   input  logic [N_CORES-1:0]              wrEn,
   input  logic [N_CORES*ADDR_WIDTH-1:0]   address,
   input  logic [N_CORES*DATA_WIDTH-1:0]   dataIn,
   output logic [N_CORES-1:0]              gnt,
   output logic [N_CORES-1:0]              rdValid,
   output logic [DATA_WIDTH-1:0]           dataOut,
   output logic                            ram_wrEn,
   output logic [ADDR_WIDTH-1:0]           ram_address,
   output logic [DATA_WIDTH-1:0]           ram_dataIn,
   input  logic [DATA_WIDTH-1:0]           ram_dataOut
);

   localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] ptr_nxt;
   logic          win_vld;

   // Slot registers: the captured access lives directly in the RAM-facing
   // output registers; only the winner index and read flag are kept aside
   // so the read can be steered to rdValid one cycle later.
   logic [PW-1:0] slot_idx;
   logic          slot_rd;
   logic          slot_vld;

   // Round-robin search starting at ptr, wrapping at N_CORES.
   always_comb begin
      int j;
      win     = '0;
      win_vld = 1'b0;
      j       = 0;
      for (int i = 0; i < N_CORES; i++) begin
         j = int'(ptr) + i;
         if (j >= N_CORES) j = j - N_CORES;
         if (!win_vld && req[j]) begin
            win_vld = 1'b1;
            win     = PW'(j);
         end
      end
   end

   always_comb begin
      ptr_nxt = win + 1'b1;
      if (int'(win) == N_CORES - 1) ptr_nxt = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr         <= '0;
         gnt         <= '0;
         rdValid     <= '0;
         ram_wrEn    <= 1'b0;
         ram_address <= '0;
         ram_dataIn  <= '0;
         slot_idx    <= '0;
         slot_rd     <= 1'b0;
         slot_vld    <= 1'b0;
      end else begin
         gnt      <= '0;
         ram_wrEn <= 1'b0;
         slot_vld <= win_vld;
         if (win_vld) begin
            gnt[win]    <= 1'b1;
            ram_wrEn    <= wrEn[win];
            ram_address <= address[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_dataIn  <= dataIn[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            slot_idx    <= win;
            slot_rd     <= ~wrEn[win];
            ptr         <= ptr_nxt;
         end
         // Read address was presented this cycle; RAM data arrives next
         // cycle, which is when rdValid is high.
         rdValid <= '0;
         if (slot_vld && slot_rd) rdValid[slot_idx] <= 1'b1;
      end
   end

   assign dataOut = ram_dataOut;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 12, the RAM word width.
REQ-002 The block SHALL have parameter DEPTH, default 256, the RAM word count.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), the RAM address width.
REQ-004 The block SHALL have parameter N_CORES, default 4, the requester count (2..8).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 req  input  N_CORES  per-core access request.
REQ-008 wrEn  input  N_CORES  per-core write qualifier; 1 = write, 0 = read.
REQ-009 address  input  N_CORES*ADDR_WIDTH  per-core address; core k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 dataIn  input  N_CORES*DATA_WIDTH  per-core write data, packed the same way.
REQ-011 gnt  output  N_CORES  one-hot acceptance pulse.
REQ-012 rdValid  output  N_CORES  one-hot read-data-valid pulse.
REQ-013 dataOut  output  DATA_WIDTH  read data broadcast to all cores.
REQ-014 ram_wrEn  output  1  RAM write enable.
REQ-015 ram_address  output  ADDR_WIDTH  RAM address.
REQ-016 ram_dataIn  output  DATA_WIDTH  RAM write data.
REQ-017 ram_dataOut  input  DATA_WIDTH  RAM read data; valid one cycle after the address is presented (registered address).

Function
REQ-018 Arbitration SHALL be round-robin over the asserted req bits: search from pointer ptr upward with wrap at N_CORES; the first asserted bit wins.
REQ-019 At each rising edge with any req asserted, the block SHALL capture the winner index, its wrEn, address and dataIn into slot registers, and set ptr to (winner+1) mod N_CORES.
REQ-020 ptr SHALL be unchanged on edges with no req asserted.
REQ-021 gnt[winner] SHALL be high for exactly the one cycle following the capture edge (cycle C+1), with all other gnt bits low.
REQ-022 A requester SHALL treat req still high during its gnt cycle as a new request.
REQ-023 In cycle C+1, ram_address and ram_dataIn SHALL equal the captured values, and ram_wrEn SHALL equal the captured wrEn.
REQ-024 ram_wrEn SHALL be 0 whenever no slot is valid; ram_address and ram_dataIn then hold their last values.
REQ-025 For a captured read, rdValid[winner] SHALL be high in cycle C+2 only, and dataOut SHALL equal ram_dataOut in that cycle.
REQ-026 Captured writes SHALL produce no rdValid pulse.
REQ-027 Total read latency SHALL be 2 cycles from capture edge to rdValid, and write latency 1 cycle to ram_wrEn.
REQ-028 Throughput SHALL be one access per cycle under continuous requests, with no bubbles.
REQ-029 Write then read of the same address in consecutive slots SHALL return the newly written value; no bypass logic is required because the RAM write precedes the read-address capture.
REQ-030 A single requesting core SHALL be granted on every edge it requests, regardless of ptr.
REQ-031 All outputs SHALL be registered except dataOut, which SHALL be a pass-through of ram_dataOut.

Reset
REQ-032 While rst is high, the block SHALL clear gnt, rdValid, ram_wrEn and the slot-valid flags to 0, and ram_address, ram_dataIn and ptr to 0, asynchronously.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight accesses: no rdValid for them, and no write pulse after rst rises.
REQ-034 The first edge after rst deasserts SHALL arbitrate normally, starting from ptr = 0.

Verification
REQ-035 Scenario: core 2 writes addr 0x10, data 0xABC; next cycle core 2 reads 0x10 -> gnt[2] pulses twice, ram_wrEn=1 in the first slot, then rdValid[2]=1 with dataOut=0xABC two cycles after the read capture.
REQ-036 Scenario: all four cores hold req (reads) for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3, one gnt per cycle, no bubbles.
REQ-037 Scenario: ptr=3, cores 1 and 3 request -> core 3 granted first, then core 1; ptr ends at 2.
REQ-038 Scenario: core 0 read captured, rst pulsed in the following cycle -> no rdValid, all outputs 0, ptr=0.
REQ-039 Scenario: addr 0xFF written with 0xFFF, then read by core 1 -> dataOut=0xFFF; top address is handled without wrap error.
REQ-040 Scenario: no requests for 5 cycles -> gnt=0, rdValid=0, ram_wrEn=0, ptr unchanged.
